// File: rtl/p5_pkg.sv
// Shared constants for the P5 fetch front end: boot address, IM depth and
// fetch-sequencer state encodings.
package p5_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          IM_WORDS = 1024;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;
endpackage

// File: rtl/pc_range_check.sv
// Combinational legality check for a fetch address: word aligned and inside
// the instruction-memory window [BASE, BASE + 4*WORDS).
module pc_range_check
    import p5_pkg::*;
#(
    parameter logic [31:0] BASE  = RESET_PC,
    parameter int          WORDS = IM_WORDS
) (
    input  logic [31:0] addr,
    output logic        legal
);
    // 33-bit compare so a window ending at 2^32 cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'(WORDS) * 33'd4);

    assign legal = (addr[1:0] == 2'b00)
                && ({1'b0, addr} >= {1'b0, BASE})
                && ({1'b0, addr} <  LIMIT);
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC and IF/ID register: boot, stall hold, ID redirects (with a redirect
// parked across a stall) and a sticky halt on an illegal fetch target.
module fetch_sequencer
    import p5_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC,
    parameter int          IM_WORDS_P = IM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc4_d,
    output logic        valid_d,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_cnt
);
    logic [1:0]  state;
    logic        pend_v;
    logic [31:0] pend_target;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        next_legal;

    assign pc_plus4 = pc_f + 32'd4;

    // A redirect parked during a stall outranks one arriving on the release cycle.
    always_comb begin
        next_pc = pc_plus4;
        if (pend_v)
            next_pc = pend_target;
        else if (redir_valid)
            next_pc = redir_target;
    end

    pc_range_check #(
        .BASE  (RESET_PC_P),
        .WORDS (IM_WORDS_P)
    ) u_range (
        .addr  (next_pc),
        .legal (next_legal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_BOOT;
            pc_f        <= RESET_PC_P;
            instr_d     <= 32'd0;
            pc4_d       <= 32'd0;
            valid_d     <= 1'b0;
            fault       <= 1'b0;
            fault_pc    <= 32'd0;
            fetch_cnt   <= 32'd0;
            pend_v      <= 1'b0;
            pend_target <= 32'd0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!stall) begin
                        // The delay-slot instruction is captured even when the target faults.
                        instr_d   <= instr_f;
                        pc4_d     <= pc_plus4;
                        valid_d   <= 1'b1;
                        fetch_cnt <= fetch_cnt + 32'd1;
                        pend_v    <= 1'b0;
                        if (next_legal) begin
                            pc_f <= next_pc;
                        end else begin
                            state    <= ST_FAULT;
                            fault    <= 1'b1;
                            fault_pc <= next_pc;
                        end
                    end else if (redir_valid) begin
                        pend_v      <= 1'b1;
                        pend_target <= redir_target;
                    end
                end
                ST_FAULT: begin
                    valid_d <= 1'b0;
                    instr_d <= 32'd0;
                end
                default: begin
                    state <= ST_FAULT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a behavioural IM feeds instr_f and a
// queue holds the IF/ID contents expected after each accepted fetch.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic        valid_d;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] imf(input logic [31:0] pc);
        return {pc[15:0] ^ 16'h5A00, ~pc[15:0]};
    endfunction

    assign instr_f = imf(pc_f);

    fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .instr_f      (instr_f),
        .pc_f         (pc_f),
        .instr_d      (instr_d),
        .pc4_d        (pc4_d),
        .valid_d      (valid_d),
        .fault        (fault),
        .fault_pc     (fault_pc),
        .fetch_cnt    (fetch_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({imf(pc), pc + 32'd4});
    endtask

    task automatic pop_cmp(input string name);
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            if ({instr_d, pc4_d} !== e || valid_d !== 1'b1) begin
                errors++;
                $display("FAIL %s: got instr_d=%h pc4_d=%h valid_d=%b, want %h %h 1",
                         name, instr_d, pc4_d, valid_d, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic restart();
        reset = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_target = 32'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_target = 32'd0;
        tick();
        tick();
        checks++;
        if (pc_f !== 32'h3000 || instr_d !== 0 || pc4_d !== 0 || valid_d !== 0 ||
            fault !== 0 || fault_pc !== 0 || fetch_cnt !== 0) begin
            errors++;
            $display("FAIL reset_values: pc_f=%h instr_d=%h pc4_d=%h valid_d=%b fault=%b fault_pc=%h cnt=%0d, want 3000 0 0 0 0 0 0",
                     pc_f, instr_d, pc4_d, valid_d, fault, fault_pc, fetch_cnt);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (valid_d !== 1'b0 || pc_f !== 32'h3000) begin
            errors++;
            $display("FAIL boot_cycle: valid_d=%b pc_f=%h, want 0 3000", valid_d, pc_f);
        end
        push_exp(32'h3000);
        tick();
        pop_cmp("first_fetch");
        checks++;
        if (pc_f !== 32'h3004) begin
            errors++;
            $display("FAIL first_pc: pc_f=%h, want 3004", pc_f);
        end
    endtask

    task automatic test_straight();
        restart();
        for (int i = 1; i <= 4; i++) begin
            push_exp(32'h3000 + 32'(4 * (i - 1)));
            tick();
            pop_cmp("straight_ifid");
            checks++;
            if (pc_f !== 32'h3000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL straight_pc: pc_f=%h, want %h", pc_f, 32'h3000 + 32'(4 * i));
            end
        end
        checks++;
        if (fetch_cnt !== 32'd4) begin
            errors++;
            $display("FAIL straight_cnt: fetch_cnt=%0d, want 4", fetch_cnt);
        end
    endtask

    task automatic test_redirect();
        restart();
        push_exp(32'h3000); tick(); pop_cmp("redir_pre0");
        push_exp(32'h3004); tick(); pop_cmp("redir_pre1");
        redir_valid = 1'b1; redir_target = 32'h3100;
        push_exp(32'h3008);
        tick();
        redir_valid = 1'b0;
        pop_cmp("redir_delay_slot");
        checks++;
        if (pc_f !== 32'h3100) begin
            errors++;
            $display("FAIL redir_pc: pc_f=%h, want 3100", pc_f);
        end
        push_exp(32'h3100);
        tick();
        pop_cmp("redir_target_fetch");
        checks++;
        if (pc_f !== 32'h3104 || fetch_cnt !== 32'd4) begin
            errors++;
            $display("FAIL redir_follow: pc_f=%h cnt=%0d, want 3104 4", pc_f, fetch_cnt);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            redir_valid  = (i == 1);
            redir_target = (i == 1) ? 32'h3040 : 32'h3300;
            tick();
            checks++;
            if (pc_f !== 32'h3104 || instr_d !== imf(32'h3100) || pc4_d !== 32'h3104 ||
                valid_d !== 1'b1 || fetch_cnt !== 32'd4) begin
                errors++;
                $display("FAIL stall_hold: pc_f=%h instr_d=%h pc4_d=%h valid_d=%b cnt=%0d, want 3104 %h 3104 1 4",
                         pc_f, instr_d, pc4_d, valid_d, fetch_cnt, imf(32'h3100));
            end
        end
        stall = 1'b0;
        redir_valid = 1'b1; redir_target = 32'h3200;
        push_exp(32'h3104);
        tick();
        redir_valid = 1'b0;
        pop_cmp("stall_release_ifid");
        checks++;
        if (pc_f !== 32'h3040 || fetch_cnt !== 32'd5) begin
            errors++;
            $display("FAIL pending_redirect: pc_f=%h cnt=%0d, want 3040 5", pc_f, fetch_cnt);
        end
        push_exp(32'h3040);
        tick();
        pop_cmp("pending_cleared_ifid");
        checks++;
        if (pc_f !== 32'h3044) begin
            errors++;
            $display("FAIL pending_cleared: pc_f=%h, want 3044", pc_f);
        end
    endtask

    task automatic check_fault_hold(input string name, input logic [31:0] fpc,
                                    input logic [31:0] hpc, input logic [31:0] cnt);
        for (int i = 0; i < 3; i++) begin
            stall = (i == 1);
            redir_valid = (i == 2); redir_target = 32'h3010;
            tick();
            checks++;
            if (fault !== 1'b1 || fault_pc !== fpc || pc_f !== hpc || valid_d !== 1'b0 ||
                instr_d !== 32'd0 || fetch_cnt !== cnt) begin
                errors++;
                $display("FAIL %s: fault=%b fault_pc=%h pc_f=%h valid_d=%b instr_d=%h cnt=%0d, want 1 %h %h 0 0 %0d",
                         name, fault, fault_pc, pc_f, valid_d, instr_d, fetch_cnt, fpc, hpc, cnt);
            end
        end
        stall = 1'b0; redir_valid = 1'b0;
    endtask

    task automatic test_fault();
        restart();
        push_exp(32'h3000); tick(); pop_cmp("mis_pre");
        redir_valid = 1'b1; redir_target = 32'h3002;
        push_exp(32'h3004);
        tick();
        redir_valid = 1'b0;
        pop_cmp("mis_delay_slot");
        checks++;
        if (fault !== 1'b1 || fault_pc !== 32'h3002 || pc_f !== 32'h3004 || fetch_cnt !== 32'd2) begin
            errors++;
            $display("FAIL mis_fault: fault=%b fault_pc=%h pc_f=%h cnt=%0d, want 1 3002 3004 2",
                     fault, fault_pc, pc_f, fetch_cnt);
        end
        check_fault_hold("mis_hold", 32'h3002, 32'h3004, 32'd2);

        restart();
        redir_valid = 1'b1; redir_target = 32'h4000;
        push_exp(32'h3000);
        tick();
        redir_valid = 1'b0;
        pop_cmp("oor_delay_slot");
        check_fault_hold("oor_hold", 32'h4000, 32'h3000, 32'd1);

        restart();
        redir_valid = 1'b1; redir_target = 32'h3FFC;
        push_exp(32'h3000);
        tick();
        redir_valid = 1'b0;
        pop_cmp("top_word_redir");
        checks++;
        if (pc_f !== 32'h3FFC || fault !== 1'b0) begin
            errors++;
            $display("FAIL top_word_legal: pc_f=%h fault=%b, want 3ffc 0", pc_f, fault);
        end
        push_exp(32'h3FFC);
        tick();
        pop_cmp("top_word_fetch");
        checks++;
        if (fault !== 1'b1 || fault_pc !== 32'h4000 || pc_f !== 32'h3FFC) begin
            errors++;
            $display("FAIL run_off_end: fault=%b fault_pc=%h pc_f=%h, want 1 4000 3ffc",
                     fault, fault_pc, pc_f);
        end
    endtask

    task automatic test_reset_in_fault();
        reset = 1'b0;
        tick();
        checks++;
        if (pc_f !== 32'h3000 || instr_d !== 0 || pc4_d !== 0 || valid_d !== 0 ||
            fault !== 0 || fault_pc !== 0 || fetch_cnt !== 0) begin
            errors++;
            $display("FAIL fault_reset: pc_f=%h instr_d=%h pc4_d=%h valid_d=%b fault=%b fault_pc=%h cnt=%0d, want 3000 0 0 0 0 0 0",
                     pc_f, instr_d, pc4_d, valid_d, fault, fault_pc, fetch_cnt);
        end
        reset = 1'b1;
        exp_q.delete();
        tick();
        checks++;
        if (valid_d !== 1'b0 || pc_f !== 32'h3000) begin
            errors++;
            $display("FAIL reboot_cycle: valid_d=%b pc_f=%h, want 0 3000", valid_d, pc_f);
        end
        push_exp(32'h3000);
        tick();
        pop_cmp("reboot_fetch");
        checks++;
        if (pc_f !== 32'h3004 || fault !== 1'b0 || fetch_cnt !== 32'd1) begin
            errors++;
            $display("FAIL reboot_run: pc_f=%h fault=%b cnt=%0d, want 3004 0 1", pc_f, fault, fetch_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_redirect();
        test_stall();
        test_fault();
        test_reset_in_fault();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
